vec_chunk_fifo: RTL and testbench

Chunking input buffer directly upstream of the vector weight-bias MACC stage. Accepts `WorkingRegs`-wide chunks from the previous layer or the audio front end and stores them in a circular buffer. Asserts `in_data_ready` only once a complete `InVecLength` vector is resident. Serves one chunk per cycle on `req_chunk`, matching the MACC's single-cycle-FIFO contract (`in_data_ready` / `req_chunk_in` / `in_data`).

---
 rtl/mlops_pkg.sv | 17 +
 rtl/chunk_ptr_ctr.sv | 39 +++
 rtl/vec_chunk_fifo.sv | 179 +++++++++++++++++
 tb/tb_vec_chunk_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mlops_pkg.sv
// Shared types for the MLOps datapath blocks: chunk-FIFO status encoding and
// a helper for sizing counters whose modulus may be 1.
package mlops_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2,
    FULL    = 2'd3
  } vf_state_e;

  // A modulus-1 counter still needs a 1-bit register to be a legal vector.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/chunk_ptr_ctr.sv
// Wrapping up-counter used for the FIFO pointers and the per-vector chunk
// index; wrap_o strobes on the increment that returns the count to zero.
module chunk_ptr_ctr
  import mlops_pkg::*;
#(
  parameter int unsigned Modulus = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           inc_i,
  output logic [cnt_width(Modulus)-1:0]  count_o,
  output logic                           wrap_o
);

  localparam int unsigned W = cnt_width(Modulus);
  localparam logic [W-1:0] Last = W'(Modulus - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = (count_q == Last) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = inc_i && (count_q == Last);

endmodule

// File: rtl/vec_chunk_fifo.sv
// Chunk FIFO ahead of the weight-bias MACC: signals ready only once a whole
// vector is resident. Optional sticky error flags via VEC_CHUNK_FIFO_ERR_EN.
module vec_chunk_fifo
  import mlops_pkg::*;
#(
  parameter int unsigned InVecLength = 8,
  parameter int unsigned WorkingRegs = 2,
  parameter int unsigned NBits       = 16,
  parameter int unsigned DepthVecs   = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   wr_en,
  input  logic signed [WorkingRegs-1:0][NBits-1:0] wr_data,
  output logic                                   full,
  input  logic                                   req_chunk,
  output logic signed [WorkingRegs-1:0][NBits-1:0] out_data,
  output logic                                   in_data_ready,
  output logic [$clog2(DepthVecs+1)-1:0]         vec_count
`ifdef VEC_CHUNK_FIFO_ERR_EN
  ,
  output logic                                   overflow,
  output logic                                   underflow
`endif
);

  localparam int unsigned ChunksPerVec = InVecLength / WorkingRegs;
  localparam int unsigned Depth        = DepthVecs * ChunksPerVec;
  localparam int unsigned PtrW         = cnt_width(Depth);
  localparam int unsigned SubW         = cnt_width(ChunksPerVec);
  localparam int unsigned OccW         = $clog2(Depth + 1);
  localparam int unsigned VcW          = $clog2(DepthVecs + 1);
  localparam logic [OccW-1:0] OccFull  = OccW'(Depth);

  if (InVecLength % WorkingRegs != 0) begin : g_bad_len
    $error("vec_chunk_fifo: InVecLength must be a multiple of WorkingRegs");
  end
  if (DepthVecs < 1) begin : g_bad_depth
    $error("vec_chunk_fifo: DepthVecs must be at least 1");
  end

  logic [WorkingRegs-1:0][NBits-1:0] mem [Depth];

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [SubW-1:0] wr_sub;
  logic [SubW-1:0] rd_sub;
  logic            wr_ptr_wrap;
  logic            rd_ptr_wrap;
  logic            vec_done;
  logic            vec_used;

  logic [OccW-1:0] occ_q;
  logic [OccW-1:0] occ_d;
  logic [VcW-1:0]  vec_count_q;
  logic [VcW-1:0]  vec_count_d;
  vf_state_e       state_q;
  vf_state_e       state_d;

  logic push;
  logic pop;

  // A full FIFO drops the push even when a pop frees a slot this cycle.
  assign push = wr_en && (state_q != FULL);
  assign pop  = req_chunk && (occ_q != '0);

  chunk_ptr_ctr #(.Modulus(Depth)) u_wr_ptr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_i   (push),
    .count_o (wr_ptr),
    .wrap_o  (wr_ptr_wrap)
  );

  chunk_ptr_ctr #(.Modulus(Depth)) u_rd_ptr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_i   (pop),
    .count_o (rd_ptr),
    .wrap_o  (rd_ptr_wrap)
  );

  chunk_ptr_ctr #(.Modulus(ChunksPerVec)) u_wr_sub (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_i   (push),
    .count_o (wr_sub),
    .wrap_o  (vec_done)
  );

  chunk_ptr_ctr #(.Modulus(ChunksPerVec)) u_rd_sub (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_i   (pop),
    .count_o (rd_sub),
    .wrap_o  (vec_used)
  );

  // Control only needs the sub-counter wrap strobes and raw pointers.
  logic unused_ctr_bits;
  assign unused_ctr_bits = ^{wr_ptr_wrap, rd_ptr_wrap, wr_sub, rd_sub};

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign out_data = mem[rd_ptr];

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    vec_count_d = vec_count_q;
    case ({vec_done, vec_used})
      2'b10:   vec_count_d = vec_count_q + 1'b1;
      2'b01:   vec_count_d = vec_count_q - 1'b1;
      default: vec_count_d = vec_count_q;
    endcase
  end

  // Status follows the post-update occupancy so it matches occ_q/vec_count_q.
  always_comb begin
    state_d = READY;
    if (occ_d == '0) begin
      state_d = EMPTY;
    end else if (occ_d == OccFull) begin
      state_d = FULL;
    end else if (vec_count_d == '0) begin
      state_d = FILLING;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      occ_q       <= '0;
      vec_count_q <= '0;
      state_q     <= EMPTY;
    end else begin
      occ_q       <= occ_d;
      vec_count_q <= vec_count_d;
      state_q     <= state_d;
    end
  end

  assign full          = (state_q == FULL);
  assign vec_count     = vec_count_q;
  assign in_data_ready = (vec_count_q != '0);

`ifdef VEC_CHUNK_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
      if (req_chunk && (occ_q == '0)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_vec_chunk_fifo.sv
// Directed bench for vec_chunk_fifo (8-element vectors, 2-element chunks,
// depth 2 vectors); flag checks compile in with VEC_CHUNK_FIFO_ERR_EN.
module tb_vec_chunk_fifo;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             wr_en;
  logic [1:0][15:0] wr_data;
  logic             full;
  logic             req_chunk;
  logic [1:0][15:0] out_data;
  logic             in_data_ready;
  logic [1:0]       vec_count;
`ifdef VEC_CHUNK_FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] q[$];
  int          wsub;
  int          rsub;
  int          evc;
  bit          eovf;
  bit          eudf;

  always #5 clk_in = ~clk_in;

  vec_chunk_fifo #(
    .InVecLength (8),
    .WorkingRegs (2),
    .NBits       (16),
    .DepthVecs   (2)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .req_chunk     (req_chunk),
    .out_data      (out_data),
    .in_data_ready (in_data_ready),
    .vec_count     (vec_count)
`ifdef VEC_CHUNK_FIFO_ERR_EN
    ,
    .overflow      (overflow),
    .underflow     (underflow)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Element 0 is the first element of the chunk.
  function automatic logic [31:0] mk(input logic [15:0] e0, input logic [15:0] e1);
    return {e1, e0};
  endfunction

  task automatic model_clear();
    q.delete();
    wsub = 0;
    rsub = 0;
    evc  = 0;
    eovf = 1'b0;
    eudf = 1'b0;
  endtask

  // One clock: drive at edge+1, check head before the edge, status after it.
  task automatic cyc(input bit push, input logic [31:0] d, input bit pop, input string tag);
    bit push_ok;
    bit pop_ok;
    wr_en     = push;
    wr_data   = d;
    req_chunk = pop;
    push_ok   = push && (q.size() < 8);
    pop_ok    = pop && (q.size() != 0);
    if (q.size() != 0) check_val({tag, ".out"}, out_data, q[0]);
    if (push && q.size() == 8) eovf = 1'b1;
    if (pop && q.size() == 0) eudf = 1'b1;
    @(posedge clk_in);
    #1;
    wr_en     = 1'b0;
    req_chunk = 1'b0;
    if (pop_ok) begin
      void'(q.pop_front());
      if (rsub == 3) evc--;
      rsub = (rsub + 1) % 4;
    end
    if (push_ok) begin
      q.push_back(d);
      if (wsub == 3) evc++;
      wsub = (wsub + 1) % 4;
    end
    check_val({tag, ".vc"}, 32'(vec_count), 32'(evc));
    check_val({tag, ".rdy"}, 32'(in_data_ready), 32'(evc != 0));
    check_val({tag, ".full"}, 32'(full), 32'(q.size() == 8));
`ifdef VEC_CHUNK_FIFO_ERR_EN
    check_val({tag, ".ovf"}, 32'(overflow), 32'(eovf));
    check_val({tag, ".udf"}, 32'(underflow), 32'(eudf));
`endif
    $display("[%0t] %s push=%0b pop=%0b data=0x%08h occ=%0d vec_count=%0d rdy=%0b full=%0b",
             $time, tag, push, pop, d, q.size(), vec_count, in_data_ready, full);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic async_reset(input string tag);
    #3 rst_in = 1'b1;
    #1;
    check_val({tag, ".rst_full"}, 32'(full), 32'd0);
    check_val({tag, ".rst_rdy"}, 32'(in_data_ready), 32'd0);
    check_val({tag, ".rst_vc"}, 32'(vec_count), 32'd0);
`ifdef VEC_CHUNK_FIFO_ERR_EN
    check_val({tag, ".rst_ovf"}, 32'(overflow), 32'd0);
    check_val({tag, ".rst_udf"}, 32'(underflow), 32'd0);
`endif
    $display("[%0t] %s async reset", $time, tag);
    model_clear();
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in    = 1'b1;
    wr_en     = 1'b0;
    req_chunk = 1'b0;
    wr_data   = '0;
    model_clear();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    check_val("init.full", 32'(full), 32'd0);
    check_val("init.rdy", 32'(in_data_ready), 32'd0);
    check_val("init.vc", 32'(vec_count), 32'd0);

    // 1: fill a vector, then reset asynchronously.
    for (int i = 0; i < 4; i++) cyc(1'b1, mk(16'(50 + i), 16'(60 + i)), 1'b0, "t1");
    check_val("t1.pre_rdy", 32'(in_data_ready), 32'd1);
    async_reset("t1");

    // 2: one vector of {1,2}..{7,8}.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, mk(16'(2 * i + 1), 16'(2 * i + 2)), 1'b0, "t2");
      if (i == 2) check_val("t2.rdy_3rd", 32'(in_data_ready), 32'd0);
    end
    check_val("t2.rdy", 32'(in_data_ready), 32'd1);
    check_val("t2.vc", 32'(vec_count), 32'd1);
    check_val("t2.head", out_data, 32'h0002_0001);

    // 3: pop the vector back out in order.
    for (int i = 0; i < 4; i++) begin
      check_val("t3.step", out_data, mk(16'(2 * i + 1), 16'(2 * i + 2)));
      cyc(1'b0, '0, 1'b1, "t3");
    end
    check_val("t3.rdy", 32'(in_data_ready), 32'd0);

    // 4: overfill across the pointer wrap; also push+pop while full.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, mk(16'(100 + 2 * i), 16'(101 + 2 * i)), 1'b0, "t4");
      if (i == 7) check_val("t4.full8", 32'(full), 32'd1);
    end
    check_val("t4.vc", 32'(vec_count), 32'd2);
    check_val("t4.full", 32'(full), 32'd1);
`ifdef VEC_CHUNK_FIFO_ERR_EN
    check_val("t4.ovf", 32'(overflow), 32'd1);
`endif
    cyc(1'b1, mk(16'd999, 16'd999), 1'b1, "t4pp");
    check_val("t4pp.full", 32'(full), 32'd0);
    check_val("t4pp.head", out_data, mk(16'd102, 16'd103));
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, "t4d");
    check_val("t4d.rdy", 32'(in_data_ready), 32'd0);

    // 5: steady push+pop with two chunks of lead, crossing vector edges.
    cyc(1'b1, mk(16'd200, 16'd201), 1'b0, "t5p");
    cyc(1'b1, mk(16'd202, 16'd203), 1'b0, "t5p");
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, mk(16'(300 + 2 * i), 16'(301 + 2 * i)), 1'b1, "t5");
      check_val("t5.occ", 32'(q.size()), 32'd2);
      if (i == 1) check_val("t5.vc_up", 32'(vec_count), 32'd1);
      if (i == 3) check_val("t5.vc_dn", 32'(vec_count), 32'd0);
    end
    cyc(1'b0, '0, 1'b1, "t5d");
    cyc(1'b0, '0, 1'b1, "t5d");
    check_val("t5d.rdy", 32'(in_data_ready), 32'd0);

    // 6: partial vector discarded by reset; fresh vector then empty pop.
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(16'(400 + i), 16'(410 + i)), 1'b0, "t6a");
    async_reset("t6");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, mk(16'(500 + 2 * i), 16'(501 + 2 * i)), 1'b0, "t6b");
      if (i == 2) check_val("t6.rdy_3rd", 32'(in_data_ready), 32'd0);
    end
    check_val("t6.rdy", 32'(in_data_ready), 32'd1);
    check_val("t6.head", out_data, mk(16'd500, 16'd501));
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, "t6c");
    cyc(1'b0, '0, 1'b1, "t6e");
    check_val("t6e.rdy", 32'(in_data_ready), 32'd0);
`ifdef VEC_CHUNK_FIFO_ERR_EN
    check_val("t6e.udf", 32'(underflow), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
